// File: rtl/aexm_ibuf_q_if.sv
// Fetch/decode bus between icache, the instruction queue and decode.
// No storage of its own; purely the signal bundle.
// ic_rdy is the icache backpressure; d_en is the decode advance.
interface aexm_ibuf_q_if;
    logic [31:0] ic_dat;
    logic        ic_vld;
    logic        ic_rdy;
    logic        d_en;
    logic        flush;
    logic [31:0] xIREG;
    logic        x_vld;
    logic [5:0]  xOPC;
    logic [31:0] xSIMM;
    logic [4:0]  regf_rRD;
    logic [4:0]  regf_rRA;
    logic [4:0]  regf_rRB;
    logic        cpu_interrupt;

    modport master (
        output ic_dat, ic_vld, d_en, flush,
        input  ic_rdy, xIREG, x_vld, xOPC, xSIMM,
               regf_rRD, regf_rRA, regf_rRB, cpu_interrupt
    );

    modport slave (
        input  ic_dat, ic_vld, d_en, flush,
        output ic_rdy, xIREG, x_vld, xOPC, xSIMM,
               regf_rRD, regf_rRA, regf_rRB, cpu_interrupt
    );
endinterface

// File: rtl/aexm_ibuf_q.sv
// Instruction queue front end: buffers icache words, presents head to decode, injects interrupt branch.
// Latency: a word pushed in cycle N is presented in N+1 (head read combinationally from storage).
// Backpressure: ic_rdy drops when DEPTH words are held; decode stalls via d_en=0.
module aexm_ibuf_q #(
    parameter int          DEPTH  = 4,
    parameter int          AW     = 2,
    parameter int          DBNC   = 2,
    parameter logic [31:0] INT_OP = 32'hB9CC0060
) (
    input  logic              gclk,
    input  logic              grst,
    aexm_ibuf_q_if.slave      bus,
    input  logic              rMSR_IE,
    input  logic              sys_int_i,
    output logic [AW:0]       q_count
);

    typedef enum logic [1:0] {IDLE, INJ, HOLD} state_t;

    localparam logic [5:0] OPC_IMM = 6'o54;

    state_t         state, state_nxt;
    logic [31:0]    mem [DEPTH];
    logic [AW-1:0]  rd_ptr, wr_ptr;
    logic [15:0]    rIMM;
    logic           fIMM, rLAST;
    logic [DBNC-1:0] sync;
    logic           pend;

    logic push, pop, accept, clr, deb;
    logic fimm_nxt, last_nxt;

    // Branch, return and IMM words must be followed by their partner, never by INT_OP.
    function automatic logic unsafe_op(input logic [5:0] op);
        return (op == 6'o54) || (op == 6'o55) || (op == 6'o46) ||
               (op == 6'o56) || (op == 6'o47) || (op == 6'o57);
    endfunction

    assign bus.ic_rdy   = (q_count != DEPTH[AW:0]);
    assign bus.x_vld    = (state == INJ) || (q_count != '0);
    assign bus.xIREG    = (state == INJ) ? INT_OP : mem[rd_ptr];
    assign bus.xOPC     = bus.xIREG[31:26];
    assign bus.regf_rRD = bus.xIREG[25:21];
    assign bus.regf_rRA = bus.xIREG[20:16];
    assign bus.regf_rRB = bus.xIREG[15:11];
    assign bus.xSIMM    = fIMM ? {rIMM, bus.xIREG[15:0]}
                               : {{16{bus.xIREG[15]}}, bus.xIREG[15:0]};
    assign bus.cpu_interrupt = (state == INJ);

    assign push   = bus.ic_vld && bus.ic_rdy && !bus.flush;
    assign accept = bus.d_en && bus.x_vld;
    assign pop    = accept && (state != INJ);
    assign clr    = accept && (state == INJ);
    // Debounce: the level must have been seen in every stage.
    assign deb    = &sync;

    // Prefix/class state as it will be after this cycle, so an injection decided
    // now cannot land right behind a word being accepted in the same cycle.
    assign fimm_nxt = bus.flush ? 1'b0 : (accept ? (bus.xOPC == OPC_IMM) : fIMM);
    assign last_nxt = accept ? unsafe_op(bus.xOPC) : rLAST;

    // Queue storage; not reset, validity is carried by q_count.
    always_ff @(posedge gclk) begin
        if (push) mem[wr_ptr] <= bus.ic_dat;
    end

    // Pointers and occupancy; flush overrides push and pop.
    always_ff @(posedge gclk) begin
        if (grst || bus.flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            q_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   q_count <= q_count + 1'b1;
                2'b01:   q_count <= q_count - 1'b1;
                default: q_count <= q_count;
            endcase
        end
    end

    // Immediate prefix and last-accepted-word class tracking.
    always_ff @(posedge gclk) begin
        if (grst) begin
            rIMM  <= '0;
            fIMM  <= 1'b0;
            rLAST <= 1'b0;
        end else begin
            fIMM  <= fimm_nxt;
            rLAST <= last_nxt;
            if (accept) rIMM <= bus.xIREG[15:0];
        end
    end

    // Interrupt synchroniser and pending latch, gated by the interrupt enable.
    always_ff @(posedge gclk) begin
        if (grst) begin
            sync <= '0;
            pend <= 1'b0;
        end else begin
            sync <= rMSR_IE ? DBNC'({sync, sys_int_i}) : '0;
            pend <= !clr && (pend || deb) && rMSR_IE;
        end
    end

    // Injection state register.
    always_ff @(posedge gclk) begin
        if (grst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Injection next-state: HOLD waits for one real word before re-arming.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (pend && !last_nxt && !fimm_nxt) state_nxt = INJ;
            INJ:  if (bus.d_en) state_nxt = HOLD;
            HOLD: if (pop) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_aexm_ibuf_q.sv
// Self-checking bench for aexm_ibuf_q: table-driven queue vectors plus
// hand-written immediate, interrupt and reset sequences.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_aexm_ibuf_q;

    localparam int          DEPTH  = 4;
    localparam int          AW     = 2;
    localparam int          DBNC   = 2;
    localparam logic [31:0] INT_OP = 32'hB9CC0060;

    logic          gclk = 1'b0;
    logic          grst;
    logic          rMSR_IE;
    logic          sys_int_i;
    logic [AW:0]   q_count;

    aexm_ibuf_q_if bus();

    aexm_ibuf_q #(.DEPTH(DEPTH), .AW(AW), .DBNC(DBNC), .INT_OP(INT_OP)) dut (
        .gclk      (gclk),
        .grst      (grst),
        .bus       (bus),
        .rMSR_IE   (rMSR_IE),
        .sys_int_i (sys_int_i),
        .q_count   (q_count)
    );

    always #5 gclk = ~gclk;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic        d_en;
        logic        flush;
        logic        ic_vld;
        logic [31:0] dat;
        logic [2:0]  q;
        logic        vld;
        logic        rdy;
        logic [31:0] ireg;
    } vec_t;

    vec_t tbl [17];

    task automatic step();
        @(posedge gclk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.ic_dat = '0;
        bus.ic_vld = 1'b0;
        bus.d_en   = 1'b0;
        bus.flush  = 1'b0;
        rMSR_IE    = 1'b0;
        sys_int_i  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        grst = 1'b1;
        step();
        step();
        grst = 1'b0;
    endtask

    task automatic push(input logic [31:0] w);
        bus.ic_dat = w;
        bus.ic_vld = 1'b1;
        step();
        bus.ic_vld = 1'b0;
    endtask

    initial begin
        int  n;
        bit  seen;

        // d_en flush ic_vld dat | q vld rdy ireg
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 32'h00000A0A, 3'd1, 1'b1, 1'b1, 32'h00000A0A};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 32'h00000B0B, 3'd2, 1'b1, 1'b1, 32'h00000A0A};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 32'h00000C0C, 3'd3, 1'b1, 1'b1, 32'h00000A0A};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 32'h00000D0D, 3'd4, 1'b1, 1'b0, 32'h00000A0A};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 32'h00000E0E, 3'd4, 1'b1, 1'b0, 32'h00000A0A};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,        3'd3, 1'b1, 1'b1, 32'h00000B0B};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,        3'd2, 1'b1, 1'b1, 32'h00000C0C};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,        3'd1, 1'b1, 1'b1, 32'h00000D0D};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'h0,        3'd0, 1'b0, 1'b1, 32'h0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 32'h00000E0E, 3'd1, 1'b1, 1'b1, 32'h00000E0E};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 32'h00000F0F, 3'd1, 1'b1, 1'b1, 32'h00000F0F};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 32'h00001111, 3'd2, 1'b1, 1'b1, 32'h00000F0F};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 32'h00002222, 3'd3, 1'b1, 1'b1, 32'h00000F0F};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 32'h00003333, 3'd4, 1'b1, 1'b0, 32'h00000F0F};
        tbl[14] = '{1'b0, 1'b1, 1'b1, 32'h00004444, 3'd0, 1'b0, 1'b1, 32'h0};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 32'h00005555, 3'd1, 1'b1, 1'b1, 32'h00005555};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 32'h0,        3'd0, 1'b0, 1'b1, 32'h0};

        // ---- reset state ----
        do_reset();
        chk("rst_q_count", 32'(q_count), 32'd0);
        chk("rst_ic_rdy", 32'(bus.ic_rdy), 32'd1);
        chk("rst_x_vld", 32'(bus.x_vld), 32'd0);
        chk("rst_cpu_int", 32'(bus.cpu_interrupt), 32'd0);

        // ---- queue fill / drain / wrap / flush vectors ----
        for (int i = 0; i < 17; i++) begin
            bus.d_en   = tbl[i].d_en;
            bus.flush  = tbl[i].flush;
            bus.ic_vld = tbl[i].ic_vld;
            bus.ic_dat = tbl[i].dat;
            step();
            chk($sformatf("vec%0d_q_count", i), 32'(q_count), 32'(tbl[i].q));
            chk($sformatf("vec%0d_x_vld", i), 32'(bus.x_vld), 32'(tbl[i].vld));
            chk($sformatf("vec%0d_ic_rdy", i), 32'(bus.ic_rdy), 32'(tbl[i].rdy));
            if (tbl[i].vld)
                chk($sformatf("vec%0d_xIREG", i), bus.xIREG, tbl[i].ireg);
        end
        idle_inputs();

        // ---- IMM prefix ----
        do_reset();
        push(32'hB0000012);
        push(32'h20A0FFFE);
        chk("imm_head_simm", bus.xSIMM, 32'h00000012);
        bus.d_en = 1'b1;
        step();
        bus.d_en = 1'b0;
        chk("imm_second_ireg", bus.xIREG, 32'h20A0FFFE);
        chk("imm_second_simm", bus.xSIMM, 32'h0012FFFE);
        step();
        chk("imm_stall_simm", bus.xSIMM, 32'h0012FFFE);
        bus.d_en = 1'b1;
        step();
        bus.d_en = 1'b0;
        chk("imm_drained", 32'(q_count), 32'd0);
        push(32'h20A0FFFE);
        chk("noimm_simm", bus.xSIMM, 32'hFFFFFFFE);

        // ---- interrupt: IE=0 blocks, short pulse ignored, held level injects ----
        do_reset();
        sys_int_i = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.cpu_interrupt) seen = 1'b1;
        end
        chk("ie0_no_inject", 32'(seen), 32'd0);

        do_reset();
        rMSR_IE   = 1'b1;
        sys_int_i = 1'b1;
        step();
        sys_int_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.cpu_interrupt) seen = 1'b1;
        end
        chk("pulse_no_inject", 32'(seen), 32'd0);

        do_reset();
        push(32'h00000777);
        rMSR_IE   = 1'b1;
        sys_int_i = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.cpu_interrupt && n < 20);
        chk("held_inject_latency", 32'(n), 32'(DBNC + 2));
        chk("inj_xIREG", bus.xIREG, INT_OP);
        chk("inj_x_vld", 32'(bus.x_vld), 32'd1);
        chk("inj_xOPC", 32'(bus.xOPC), 32'(6'o56));
        chk("inj_rRD", 32'(bus.regf_rRD), 32'd14);
        chk("inj_rRA", 32'(bus.regf_rRA), 32'd12);
        chk("inj_xSIMM", bus.xSIMM, 32'h00000060);
        chk("inj_q_kept", 32'(q_count), 32'd1);

        // ---- reset while injecting ----
        grst = 1'b1;
        step();
        chk("rst_inj_cpu_int", 32'(bus.cpu_interrupt), 32'd0);
        chk("rst_inj_q_count", 32'(q_count), 32'd0);
        chk("rst_inj_x_vld", 32'(bus.x_vld), 32'd0);
        grst      = 1'b0;
        sys_int_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.cpu_interrupt) seen = 1'b1;
        end
        chk("rst_inj_pend_dropped", 32'(seen), 32'd0);

        // ---- no injection in a delay slot ----
        do_reset();
        rMSR_IE = 1'b1;
        push(32'hB8000010);   // bri
        push(32'h00221800);   // delay slot
        push(32'h00642000);   // add
        bus.d_en = 1'b1;
        step();
        bus.d_en = 1'b0;
        chk("bri_accepted_head", bus.xIREG, 32'h00221800);
        sys_int_i = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < DBNC + 4; i++) begin
            step();
            if (bus.cpu_interrupt) seen = 1'b1;
        end
        chk("slot_no_inject", 32'(seen), 32'd0);
        chk("slot_head_kept", bus.xIREG, 32'h00221800);
        bus.d_en = 1'b1;
        step();
        chk("after_slot_cpu_int", 32'(bus.cpu_interrupt), 32'd1);
        chk("after_slot_xIREG", bus.xIREG, INT_OP);
        chk("after_slot_q_count", 32'(q_count), 32'd1);
        step();
        chk("hold_cpu_int", 32'(bus.cpu_interrupt), 32'd0);
        chk("hold_xIREG_add", bus.xIREG, 32'h00642000);
        chk("hold_q_count", 32'(q_count), 32'd1);
        bus.d_en  = 1'b0;
        rMSR_IE   = 1'b0;
        sys_int_i = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
